// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC averaging front end.
package sar_pkg;
  typedef enum logic [1:0] {IDLE, ARM, WAIT, GAP} state_t;

  localparam int DEF_ADC_WIDTH = 8;

  // Bits needed for a down-counter that is loaded with n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sar_avg_acc.sv
// Sums 2^OSR_LOG2 samples, rounds half-up, holds the result on a valid/ready port.
// Result registers one cycle after the final sample; a result arriving while stalled is dropped and flagged.
module sar_avg_acc
  import sar_pkg::*;
#(
  parameter int ADC_WIDTH = DEF_ADC_WIDTH,
  parameter int OSR_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_vld,
  input  logic [ADC_WIDTH-1:0] sample,
  input  logic                 avg_ready,
  input  logic                 clr_flags,
  output logic [ADC_WIDTH-1:0] avg_data,
  output logic                 avg_valid,
  output logic                 overrun
);
  localparam int AW = ADC_WIDTH + OSR_LOG2;
  localparam int CW = OSR_LOG2 + 1;
  localparam logic [AW-1:0] RND  = AW'((2 ** OSR_LOG2) / 2);
  localparam logic [CW-1:0] LAST = CW'((2 ** OSR_LOG2) - 1);

  logic [AW-1:0]        acc;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        rounded;
  logic [ADC_WIDTH-1:0] result;
  logic [CW-1:0]        cnt;
  logic                 done;
  logic                 drop;

  // Worst case sum plus rounding term stays below 2^AW, so no extra bit is needed.
  always_comb begin
    sum     = acc + AW'(sample);
    rounded = sum + RND;
    result  = ADC_WIDTH'(rounded >> OSR_LOG2);
    done    = sample_vld && (cnt == LAST);
    drop    = done && avg_valid && !avg_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg_data  <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample_vld) begin
        if (done) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end

      if (done && (!avg_valid || avg_ready)) begin
        avg_data  <= result;
        avg_valid <= 1'b1;
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sar_adc_avg.sv
// Paces SAR_ADC conversions at a fixed PERIOD and averages 2^OSR_LOG2 results.
// Output valid one cycle after the final den; stalled output drops new results (overrun), missing den flags timeout.
module sar_adc_avg
  import sar_pkg::*;
#(
  parameter int ADC_WIDTH = DEF_ADC_WIDTH,
  parameter int OSR_LOG2  = 2,
  parameter int PERIOD    = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 start,
  input  logic                 den,
  input  logic [ADC_WIDTH-1:0] Dout,
  output logic [ADC_WIDTH-1:0] avg_data,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic                 overrun,
  output logic                 timeout,
  input  logic                 clr_flags
);
  localparam int PW = cnt_width(PERIOD);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [PW-1:0] PER_LOAD = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic          sample_vld;
  logic          to_evt;
  logic          period_end;

  // per_cnt free-runs modulo PERIOD from ARM, so value 1 marks the cycle before every cadence slot.
  assign period_end = (per_cnt == PW'(1));

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    sample_vld = 1'b0;
    to_evt     = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = ARM;
      ARM: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (den) begin
          sample_vld = 1'b1;
          state_nxt  = GAP;
        end else if (to_cnt == '0) begin
          to_evt    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: if (period_end) state_nxt = en ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      per_cnt <= '0;
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ARM) begin
        per_cnt <= PER_LOAD;
        to_cnt  <= TO_LOAD;
      end else if (state != IDLE) begin
        per_cnt <= (per_cnt == '0) ? PER_LOAD : per_cnt - PW'(1);
        if (state == WAIT && to_cnt != '0) to_cnt <= to_cnt - TW'(1);
      end

      if (to_evt) begin
        timeout <= 1'b1;
      end else if (clr_flags) begin
        timeout <= 1'b0;
      end
    end
  end

  sar_avg_acc #(
    .ADC_WIDTH(ADC_WIDTH),
    .OSR_LOG2 (OSR_LOG2)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .sample_vld(sample_vld),
    .sample    (Dout),
    .avg_ready (avg_ready),
    .clr_flags (clr_flags),
    .avg_data  (avg_data),
    .avg_valid (avg_valid),
    .overrun   (overrun)
  );
endmodule

// File: tb/tb_sar_adc_avg.sv
// Bench for sar_adc_avg: behavioural SAR_ADC responder, output monitor, per-scenario checks.
module tb_sar_adc_avg;
  localparam int W = 8;
  localparam int O = 2;
  localparam int P = 16;
  localparam int T = 32;
  localparam int N = 1 << O;

  logic         clk = 1'b0;
  logic         rst, en, start, den, avg_valid, avg_ready, overrun, timeout, clr_flags;
  logic [W-1:0] Dout, avg_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sar_adc_avg #(.ADC_WIDTH(W), .OSR_LOG2(O), .PERIOD(P), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .den(den), .Dout(Dout),
    .avg_data(avg_data), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .overrun(overrun), .timeout(timeout), .clr_flags(clr_flags)
  );

  // Behavioural ADC: answers each start with den after W+1 cycles, optionally misses one
  // conversion or emits a stray den while the averager is not waiting.
  int dq[$];
  int const_val = 153;
  bit drop_next = 1'b0;
  bit spur      = 1'b0;
  int cd        = 0;
  int sp_cd     = 0;

  initial begin
    den  = 1'b0;
    Dout = '0;
    forever begin
      @(negedge clk);
      den = 1'b0;
      if (start) begin
        cd = W + 1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (drop_next) begin
            drop_next = 1'b0;
          end else begin
            den  = 1'b1;
            Dout = W'(dq.size() > 0 ? dq.pop_front() : const_val);
            if (spur) sp_cd = 3;
          end
        end
      end else if (sp_cd > 0) begin
        sp_cd--;
        if (sp_cd == 0) begin
          den  = 1'b1;
          Dout = '1;
        end
      end
    end
  end

  // Monitor: cycle count, start times, den count and accepted results.
  int cyc     = 0;
  int den_cnt = 0;
  int start_t[$];
  int got[$];

  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (start) start_t.push_back(cyc);
    if (den) den_cnt++;
    if (avg_valid && avg_ready) got.push_back(int'(avg_data));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Reference: mean of N consecutive samples, rounded half up.
  function automatic int avg_ref(input int v[$], input int idx);
    int s = 0;
    for (int i = 0; i < N; i++) s += v[idx + i];
    return $rtoi($floor(real'(s) / real'(N) + 0.5));
  endfunction

  function automatic int got_at(input int idx);
    return (got.size() > idx) ? got[idx] : -1;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enables conversions until n more results are accepted, then stops and lets the FSM idle.
  task automatic run_avgs(input int n, output bit ok);
    int base = got.size();
    int b = 0;
    en = 1'b1;
    while (got.size() < base + n && b < 150 * n) begin
      @(negedge clk);
      b++;
    end
    ok = (got.size() >= base + n);
    en = 1'b0;
    idle_cycles(24);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; avg_ready = 1'b1; clr_flags = 1'b0;
    idle_cycles(3);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
    checks++; if (avg_data !== '0) begin errors++; $display("FAIL reset_avg_data got=%0d exp=0", avg_data); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid got=%b exp=0", avg_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_constant;
    bit ok;
    int s0 = start_t.size();
    int g0 = got.size();
    dq.delete();
    const_val = 153;
    run_avgs(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL const_timeout got=%0d results exp=2", got.size() - g0); end
    checks++; if (got_at(g0) !== 153) begin errors++; $display("FAIL const_avg0 got=%0d exp=153", got_at(g0)); end
    checks++; if (got_at(g0 + 1) !== 153) begin errors++; $display("FAIL const_avg1 got=%0d exp=153", got_at(g0 + 1)); end
    checks++; if (start_t.size() - s0 !== 2 * N) begin errors++; $display("FAIL const_starts got=%0d exp=%0d", start_t.size() - s0, 2 * N); end
    for (int i = 1; i < 4 && s0 + i < start_t.size(); i++) begin
      checks++;
      if (start_t[s0 + i] - start_t[s0 + i - 1] !== P) begin
        errors++; $display("FAIL const_cadence%0d got=%0d exp=%0d", i, start_t[s0 + i] - start_t[s0 + i - 1], P);
      end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL const_overrun got=%b exp=0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL const_timeout_flag got=%b exp=0", timeout); end
  endtask

  task automatic test_rounding;
    bit ok;
    int g0 = got.size();
    dq = '{10, 11, 11, 11, 10, 10, 10, 11};
    run_avgs(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL round_timeout got=%0d results exp=2", got.size() - g0); end
    checks++; if (got_at(g0) !== 11) begin errors++; $display("FAIL round_up got=%0d exp=11", got_at(g0)); end
    checks++; if (got_at(g0 + 1) !== 10) begin errors++; $display("FAIL round_down got=%0d exp=10", got_at(g0 + 1)); end
  endtask

  task automatic test_full_scale;
    bit ok;
    int g0 = got.size();
    dq = '{255, 255, 255, 255, 0, 0, 0, 0};
    run_avgs(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout got=%0d results exp=2", got.size() - g0); end
    checks++; if (got_at(g0) !== 255) begin errors++; $display("FAIL full_max got=%0d exp=255", got_at(g0)); end
    checks++; if (got_at(g0 + 1) !== 0) begin errors++; $display("FAIL full_zero got=%0d exp=0", got_at(g0 + 1)); end
  endtask

  task automatic test_random;
    bit ok;
    int vals[$];
    int g0 = got.size();
    for (int i = 0; i < 6 * N; i++) vals.push_back(int'($urandom_range(0, 255)));
    dq = vals;
    spur = 1'b1;
    run_avgs(6, ok);
    spur = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got=%0d results exp=6", got.size() - g0); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_at(g0 + k) !== avg_ref(vals, k * N)) begin
        errors++; $display("FAIL rand_avg%0d got=%0d exp=%0d", k, got_at(g0 + k), avg_ref(vals, k * N));
      end
    end
  endtask

  task automatic test_backpressure;
    int d0 = den_cnt;
    int b = 0;
    int g0;
    avg_ready = 1'b0;
    dq = '{153, 153, 153, 153, 100, 100, 100, 100};
    en = 1'b1;
    while (den_cnt < d0 + 2 * N && b < 400) begin @(negedge clk); b++; end
    checks++; if (den_cnt < d0 + 2 * N) begin errors++; $display("FAIL bp_timeout got=%0d dens exp=%0d", den_cnt - d0, 2 * N); end
    idle_cycles(2);
    en = 1'b0;
    idle_cycles(24);
    checks++; if (avg_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid got=%b exp=1", avg_valid); end
    checks++; if (avg_data !== 8'd153) begin errors++; $display("FAIL bp_held_data got=%0d exp=153", avg_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    g0 = got.size();
    avg_ready = 1'b1;
    idle_cycles(3);
    checks++; if (got.size() - g0 !== 1) begin errors++; $display("FAIL bp_transfers got=%0d exp=1", got.size() - g0); end
    checks++; if (got_at(g0) !== 153) begin errors++; $display("FAIL bp_data got=%0d exp=153", got_at(g0)); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", avg_valid); end
    clr_flags = 1'b1;
    idle_cycles(1);
    clr_flags = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_timeout;
    int s0 = start_t.size();
    int g0 = got.size();
    int b = 0;
    int d1;
    dq = '{40, 41, 42, 43};
    drop_next = 1'b1;
    en = 1'b1;
    @(negedge clk);
    while (start !== 1'b1 && b < 5) begin @(negedge clk); b++; end
    repeat (T) @(negedge clk);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", timeout); end
    @(negedge clk);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag got=%b exp=1", timeout); end
    b = 0;
    while (got.size() < g0 + 1 && b < 400) begin @(negedge clk); b++; end
    en = 1'b0;
    idle_cycles(24);
    checks++; if (got_at(g0) !== 42) begin errors++; $display("FAIL to_avg got=%0d exp=42", got_at(g0)); end
    checks++; if (start_t.size() - s0 !== N + 1) begin errors++; $display("FAIL to_starts got=%0d exp=%0d", start_t.size() - s0, N + 1); end
    d1 = (start_t.size() > s0 + 1) ? start_t[s0 + 1] - start_t[s0] : 0;
    checks++; if (d1 % P !== 0 || d1 <= T) begin errors++; $display("FAIL to_cadence got=%0d exp=multiple of %0d beyond %0d", d1, P, T); end
    d1 = (start_t.size() > s0 + 2) ? start_t[s0 + 2] - start_t[s0 + 1] : 0;
    checks++; if (d1 !== P) begin errors++; $display("FAIL to_cadence_next got=%0d exp=%0d", d1, P); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d0 = den_cnt;
    int b = 0;
    int g0;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL rm_pre_timeout got=%b exp=1", timeout); end
    dq = '{200, 200};
    en = 1'b1;
    while (den_cnt < d0 + 2 && b < 200) begin @(negedge clk); b++; end
    idle_cycles(2);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rm_start got=%b exp=0", start); end
    checks++; if (avg_data !== '0) begin errors++; $display("FAIL rm_avg_data got=%0d exp=0", avg_data); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL rm_avg_valid got=%b exp=0", avg_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rm_overrun got=%b exp=0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rm_timeout got=%b exp=0", timeout); end
    rst = 1'b0;
    idle_cycles(20);
    dq = '{50, 50, 50, 50};
    g0 = got.size();
    run_avgs(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_run_timeout got=%0d results exp=1", got.size() - g0); end
    checks++; if (got_at(g0) !== 50) begin errors++; $display("FAIL rm_fresh_avg got=%0d exp=50", got_at(g0)); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; avg_ready = 1'b1; clr_flags = 1'b0;
    test_reset;
    test_constant;
    test_rounding;
    test_full_scale;
    test_random;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
